// File: rtl/mesi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mesi_pkg
// Purpose  : Shared types and constants for the snooping MESI system.
//            It defines the line states, the bus messages, and the bit
//            fields of a cache line and of a processor instruction.
// Revision : 1.0 - initial release
// ============================================================================
package mesi_pkg;

   localparam int LINES  = 4;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int IDX_W  = $clog2(LINES);
   localparam int LINE_W = ADDR_W + 3 + DATA_W;

   // Cache line fields: {tag, state, data}
   localparam int c_line_tag_hi = 13;
   localparam int c_line_tag_lo = 11;
   localparam int c_line_st_hi  = 10;
   localparam int c_line_st_lo  = 8;
   localparam int c_line_dat_hi = 7;
   localparam int c_line_dat_lo = 0;

   // Instruction fields: {pid, op, addr, data}
   localparam int c_ins_pid_hi  = 13;
   localparam int c_ins_pid_lo  = 12;
   localparam int c_ins_op_bit  = 11;
   localparam int c_ins_adr_hi  = 10;
   localparam int c_ins_adr_lo  = 8;
   localparam int c_ins_dat_hi  = 7;
   localparam int c_ins_dat_lo  = 0;

   typedef enum logic [2:0] {
      ST_INVALID   = 3'b000,
      ST_SHARED    = 3'b001,
      ST_EXCLUSIVE = 3'b010,
      ST_MODIFIED  = 3'b011
   } mesi_state_t;

   typedef enum logic [1:0] {
      MSG_NONE       = 2'b00,
      MSG_READ_MISS  = 2'b01,
      MSG_WRITE_MISS = 2'b10,
      MSG_INVALIDATE = 2'b11
   } bus_msg_t;

   function automatic logic [LINE_W-1:0] make_line(input logic [ADDR_W-1:0] tag,
                                                   input mesi_state_t        st,
                                                   input logic [DATA_W-1:0]  data);
      return {tag, st, data};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mesi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mesi_cache_ctrl
// Purpose  : A direct-mapped MESI cache with its controller. In one cycle it
//            acts either as the requester (a hit or a miss, a victim
//            write-back, a bus message) or as a snooper reacting to another
//            cache's bus message.
// Ports    : clk, rst (async); i_req/i_rd/i_addr/i_wdata = current instruction;
//            i_bus_msg = message from the requester;
//            i_snp_m/i_snp_se/i_snp_data = aggregated snooper status;
//            i_mem_data = memory word at i_addr;
//            o_msg, o_victim_* = requester outputs;
//            o_hold_m/o_hold_se/o_line_data = this cache's snoop status
// Revision : 1.0 - initial release
// ============================================================================
module mesi_cache_ctrl
   import mesi_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_rd,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  bus_msg_t          i_bus_msg,
   input  logic              i_snp_m,
   input  logic              i_snp_se,
   input  logic [DATA_W-1:0] i_snp_data,
   input  logic [DATA_W-1:0] i_mem_data,
   output bus_msg_t          o_msg,
   output logic              o_hold_m,
   output logic              o_hold_se,
   output logic [DATA_W-1:0] o_line_data,
   output logic              o_victim_wb,
   output logic [ADDR_W-1:0] o_victim_addr,
   output logic [DATA_W-1:0] o_victim_data
);

   logic [LINE_W-1:0] cache_data [0:LINES-1];

   logic [IDX_W-1:0]  w_idx;
   logic [LINE_W-1:0] w_line;
   logic [ADDR_W-1:0] w_tag;
   mesi_state_t       w_state;
   logic [DATA_W-1:0] w_data;
   logic              w_hit;
   logic              w_wr_en;
   logic [LINE_W-1:0] w_next_line;

   assign w_idx   = i_addr[IDX_W-1:0];
   assign w_line  = cache_data[w_idx];
   assign w_tag   = w_line[c_line_tag_hi:c_line_tag_lo];
   assign w_state = mesi_state_t'(w_line[c_line_st_hi:c_line_st_lo]);
   assign w_data  = w_line[c_line_dat_hi:c_line_dat_lo];
   // A matching tag in INVALID still counts as a miss.
   assign w_hit   = (w_tag == i_addr) && (w_state != ST_INVALID);

   assign o_hold_m      = w_hit && (w_state == ST_MODIFIED);
   assign o_hold_se     = w_hit && ((w_state == ST_SHARED) || (w_state == ST_EXCLUSIVE));
   assign o_line_data   = w_data;
   assign o_victim_addr = w_tag;
   assign o_victim_data = w_data;

   // The bus message and the victim flag depend only on this cache. They
   // are kept apart from the next-line logic so the bus message does not
   // loop back through the snoop inputs.
   always_comb begin
      o_msg       = MSG_NONE;
      o_victim_wb = 1'b0;
      if (i_req && !w_hit) begin
         o_msg       = i_rd ? MSG_READ_MISS : MSG_WRITE_MISS;
         // On a miss a MODIFIED line must hold a different tag.
         o_victim_wb = (w_state == ST_MODIFIED);
      end else if (i_req && !i_rd && (w_state == ST_SHARED)) begin
         o_msg = MSG_INVALIDATE;
      end
   end

   always_comb begin
      w_wr_en     = 1'b0;
      w_next_line = w_line;
      if (i_req) begin
         if (i_rd) begin
            if (!w_hit) begin
               w_wr_en     = 1'b1;
               w_next_line = make_line(i_addr,
                                       (i_snp_m || i_snp_se) ? ST_SHARED : ST_EXCLUSIVE,
                                       i_snp_m ? i_snp_data : i_mem_data);
            end
         end else begin
            // Every write leaves the requester MODIFIED with the new data.
            w_wr_en     = 1'b1;
            w_next_line = make_line(i_addr, ST_MODIFIED, i_wdata);
         end
      end else if (w_hit) begin
         case (i_bus_msg)
            MSG_READ_MISS: begin
               w_wr_en     = 1'b1;
               w_next_line = make_line(w_tag, ST_SHARED, w_data);
            end
            MSG_WRITE_MISS, MSG_INVALIDATE: begin
               w_wr_en     = 1'b1;
               w_next_line = make_line(w_tag, ST_INVALID, w_data);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++)
            cache_data[i] <= make_line(ADDR_W'(i), ST_INVALID, '0);
      end else if (w_wr_en) begin
         cache_data[w_idx] <= w_next_line;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mesi_mem.sv
`default_nettype none
// ============================================================================
// Module   : mesi_mem
// Purpose  : Shared main memory. It has one combinational read port and two
//            write ports. Port A takes the snooper supply and port B takes
//            the requester victim. Both ports can commit in the same cycle.
// Ports    : clk, rst (async), i_raddr/o_rdata, i_we_a/i_addr_a/i_data_a,
//            i_we_b/i_addr_b/i_data_b
// Revision : 1.0 - initial release
// ============================================================================
module mesi_mem
   import mesi_pkg::*;
#(
   parameter int MEM_WORDS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   input  logic              i_we_a,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [DATA_W-1:0] i_data_a,
   input  logic              i_we_b,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [DATA_W-1:0] i_data_b
);

   logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

   assign o_rdata = mem[i_raddr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      end else begin
         if (i_we_a) mem[i_addr_a] <= i_data_a;
         if (i_we_b) mem[i_addr_b] <= i_data_b;
      end
   end

endmodule
`default_nettype wire

// File: rtl/snoop_mesi_system.sv
`default_nettype none
// ============================================================================
// Module   : snoop_mesi_system
// Purpose  : A three-processor snooping MESI system on one shared bus. It
//            executes one instruction per clock. The processor id selects
//            which cache is the requester.
// Ports    : clock, reset (async, active-high);
//            instruction[13:0] = {pid, op, addr, wdata};
//            bus_out[4:0] = {msg, addr}; wr_bus = memory write-back this cycle;
//            emitter[2:0] = one-hot id of the cache placing the message
// Revision : 1.0 - initial release
// ============================================================================
module snoop_mesi_system
   import mesi_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [13:0] instruction,
   output logic [4:0]  bus_out,
   output logic        wr_bus,
   output logic [2:0]  emitter
);

   localparam int NPROC = 3;

   logic [1:0]        w_pid;
   logic              w_rd;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [NPROC-1:0]  w_req;

   bus_msg_t          w_msg_c   [NPROC];
   logic [NPROC-1:0]  w_hold_m, w_hold_se, w_vwb;
   logic [DATA_W-1:0] w_line_d  [NPROC];
   logic [ADDR_W-1:0] w_vaddr_c [NPROC];
   logic [DATA_W-1:0] w_vdata_c [NPROC];

   bus_msg_t          w_msg;
   logic              w_vwb_any;
   logic [ADDR_W-1:0] w_vaddr;
   logic [DATA_W-1:0] w_vdata;
   logic              w_snp_m, w_snp_se, w_snp_wb;
   logic [DATA_W-1:0] w_snp_data;
   logic [DATA_W-1:0] w_mem_rdata;

   assign w_pid   = instruction[c_ins_pid_hi:c_ins_pid_lo];
   assign w_rd    = instruction[c_ins_op_bit];
   assign w_addr  = instruction[c_ins_adr_hi:c_ins_adr_lo];
   assign w_wdata = instruction[c_ins_dat_hi:c_ins_dat_lo];

   // pid 11 matches no cache, so the instruction is a no-op.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < NPROC; i++) w_req[i] = (w_pid == 2'(i));
   end

   // Snooper aggregation excludes the requester. At most one cache can hold
   // the address in MODIFIED, so an OR selects its data.
   always_comb begin
      w_snp_m    = 1'b0;
      w_snp_se   = 1'b0;
      w_snp_data = '0;
      for (int i = 0; i < NPROC; i++) begin
         if (!w_req[i]) begin
            w_snp_m  = w_snp_m  | w_hold_m[i];
            w_snp_se = w_snp_se | w_hold_se[i];
            if (w_hold_m[i]) w_snp_data = w_snp_data | w_line_d[i];
         end
      end
   end

   // Requester multiplexing
   always_comb begin
      w_msg     = MSG_NONE;
      w_vwb_any = 1'b0;
      w_vaddr   = '0;
      w_vdata   = '0;
      for (int i = 0; i < NPROC; i++) begin
         if (w_req[i]) begin
            w_msg     = w_msg_c[i];
            w_vwb_any = w_vwb[i];
            w_vaddr   = w_vaddr_c[i];
            w_vdata   = w_vdata_c[i];
         end
      end
   end

   assign w_snp_wb = w_snp_m && ((w_msg == MSG_READ_MISS) || (w_msg == MSG_WRITE_MISS));

   mesi_cache_ctrl c0 (
      .clk(clock), .rst(reset), .i_req(w_req[0]), .i_rd(w_rd), .i_addr(w_addr),
      .i_wdata(w_wdata), .i_bus_msg(w_msg), .i_snp_m(w_snp_m), .i_snp_se(w_snp_se),
      .i_snp_data(w_snp_data), .i_mem_data(w_mem_rdata), .o_msg(w_msg_c[0]),
      .o_hold_m(w_hold_m[0]), .o_hold_se(w_hold_se[0]), .o_line_data(w_line_d[0]),
      .o_victim_wb(w_vwb[0]), .o_victim_addr(w_vaddr_c[0]), .o_victim_data(w_vdata_c[0])
   );

   mesi_cache_ctrl c1 (
      .clk(clock), .rst(reset), .i_req(w_req[1]), .i_rd(w_rd), .i_addr(w_addr),
      .i_wdata(w_wdata), .i_bus_msg(w_msg), .i_snp_m(w_snp_m), .i_snp_se(w_snp_se),
      .i_snp_data(w_snp_data), .i_mem_data(w_mem_rdata), .o_msg(w_msg_c[1]),
      .o_hold_m(w_hold_m[1]), .o_hold_se(w_hold_se[1]), .o_line_data(w_line_d[1]),
      .o_victim_wb(w_vwb[1]), .o_victim_addr(w_vaddr_c[1]), .o_victim_data(w_vdata_c[1])
   );

   mesi_cache_ctrl c2 (
      .clk(clock), .rst(reset), .i_req(w_req[2]), .i_rd(w_rd), .i_addr(w_addr),
      .i_wdata(w_wdata), .i_bus_msg(w_msg), .i_snp_m(w_snp_m), .i_snp_se(w_snp_se),
      .i_snp_data(w_snp_data), .i_mem_data(w_mem_rdata), .o_msg(w_msg_c[2]),
      .o_hold_m(w_hold_m[2]), .o_hold_se(w_hold_se[2]), .o_line_data(w_line_d[2]),
      .o_victim_wb(w_vwb[2]), .o_victim_addr(w_vaddr_c[2]), .o_victim_data(w_vdata_c[2])
   );

   // Snooper supply and victim eviction always target different addresses.
   mesi_mem #(.MEM_WORDS(8)) m (
      .clk(clock), .rst(reset), .i_raddr(w_addr), .o_rdata(w_mem_rdata),
      .i_we_a(w_snp_wb),  .i_addr_a(w_addr),  .i_data_a(w_snp_data),
      .i_we_b(w_vwb_any), .i_addr_b(w_vaddr), .i_data_b(w_vdata)
   );

   always_comb begin
      bus_out = '0;
      wr_bus  = 1'b0;
      emitter = '0;
      if (!reset) begin
         if (w_msg != MSG_NONE) begin
            bus_out = {w_msg, w_addr};
            emitter = w_req;
         end
         wr_bus = w_snp_wb | w_vwb_any;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snoop_mesi_system.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_mesi_system
// Purpose  : Directed self-checking bench for snoop_mesi_system.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_mesi_system;

   localparam logic [2:0] I = 3'b000, S = 3'b001, E = 3'b010, M = 3'b011;
   localparam logic       RD = 1'b1, WR = 1'b0;

   logic        clock = 1'b0;
   logic        reset;
   logic [13:0] instruction;
   logic [4:0]  bus_out;
   logic        wr_bus;
   logic [2:0]  emitter;

   int n_checks = 0;
   int n_pass   = 0;

   snoop_mesi_system dut (
      .clock(clock), .reset(reset), .instruction(instruction),
      .bus_out(bus_out), .wr_bus(wr_bus), .emitter(emitter)
   );

   always #5 clock = ~clock;

   function automatic logic [13:0] ln(input logic [2:0] tag, input logic [2:0] st,
                                      input logic [7:0] d);
      return {tag, st, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Apply one instruction after the falling edge. Check the combinational
   // outputs, then let the rising edge commit the update.
   task automatic issue(input string tag, input logic [1:0] pid, input logic op,
                        input logic [2:0] a, input logic [7:0] d,
                        input logic [4:0] ebus, input logic ewr, input logic [2:0] eem);
      @(negedge clock);
      instruction = {pid, op, a, d};
      #1;
      check({tag, ".bus"}, 32'(bus_out), 32'(ebus));
      check({tag, ".wr"},  32'(wr_bus),  32'(ewr));
      check({tag, ".em"},  32'(emitter), 32'(eem));
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 14'h3000;
      #12;
      check("rst.c1[3]", 32'(dut.c1.cache_data[3]), 32'(ln(3'b011, I, 8'd0)));
      reset = 1'b0;

      // Run a little traffic so that reset has state to clear.
      issue("pre.w0",   2'd0, WR, 3'b000, 8'h11, 5'b10_000, 1'b0, 3'b001);
      issue("pre.w4",   2'd0, WR, 3'b100, 8'h22, 5'b10_100, 1'b1, 3'b001);
      check("pre.mem0", 32'(dut.m.mem[0]), 32'h11);
      check("pre.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b100, M, 8'h22)));

      // Assert reset asynchronously, away from any clock edge.
      @(negedge clock);
      instruction = {2'd0, RD, 3'b000, 8'h00};
      #1;
      check("mid.wr_pre", 32'(wr_bus), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid.bus",   32'(bus_out), 32'd0);
      check("mid.wr",    32'(wr_bus),  32'd0);
      check("mid.em",    32'(emitter), 32'd0);
      check("mid.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, I, 8'd0)));
      check("mid.mem0",  32'(dut.m.mem[0]), 32'd0);
      instruction = 14'h3000;
      @(negedge clock);
      reset = 1'b0;

      // Preload
      dut.c0.cache_data[0] = ln(3'b000, I, 8'd10);
      dut.c0.cache_data[1] = ln(3'b001, S, 8'd8);
      dut.c0.cache_data[2] = ln(3'b010, M, 8'd30);
      dut.c0.cache_data[3] = ln(3'b011, I, 8'd10);
      dut.c1.cache_data[0] = ln(3'b000, I, 8'd10);
      dut.c1.cache_data[1] = ln(3'b101, M, 8'd68);
      dut.c1.cache_data[2] = ln(3'b010, I, 8'd10);
      dut.c1.cache_data[3] = ln(3'b011, S, 8'd18);
      dut.c2.cache_data[0] = ln(3'b100, S, 8'd20);
      dut.c2.cache_data[1] = ln(3'b001, S, 8'd8);
      dut.c2.cache_data[2] = ln(3'b010, I, 8'd10);
      dut.c2.cache_data[3] = ln(3'b011, I, 8'd10);
      dut.m.mem[0] = 8'd10;
      dut.m.mem[1] = 8'd8;
      dut.m.mem[6] = 8'd50;

      // Sequential sharing
      issue("s1", 2'd0, RD, 3'b000, 8'd0, 5'b01_000, 1'b0, 3'b001);
      check("s1.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, E, 8'd10)));
      issue("s2", 2'd1, RD, 3'b000, 8'd0, 5'b01_000, 1'b0, 3'b010);
      check("s2.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, S, 8'd10)));
      check("s2.c1[0]", 32'(dut.c1.cache_data[0]), 32'(ln(3'b000, S, 8'd10)));

      // Upgrade, then a write miss against a MODIFIED snooper
      issue("s3", 2'd1, WR, 3'b000, 8'd30, 5'b11_000, 1'b0, 3'b010);
      check("s3.c1[0]", 32'(dut.c1.cache_data[0]), 32'(ln(3'b000, M, 8'd30)));
      check("s3.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, I, 8'd10)));
      issue("s4", 2'd0, WR, 3'b000, 8'd40, 5'b10_000, 1'b1, 3'b001);
      check("s4.mem0",  32'(dut.m.mem[0]), 32'd30);
      check("s4.c1[0]", 32'(dut.c1.cache_data[0]), 32'(ln(3'b000, I, 8'd30)));
      check("s4.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, M, 8'd40)));

      // MODIFIED supply on a read miss
      issue("s5", 2'd1, RD, 3'b000, 8'd0, 5'b01_000, 1'b1, 3'b010);
      check("s5.mem0",  32'(dut.m.mem[0]), 32'd40);
      check("s5.c0[0]", 32'(dut.c0.cache_data[0]), 32'(ln(3'b000, S, 8'd40)));
      check("s5.c1[0]", 32'(dut.c1.cache_data[0]), 32'(ln(3'b000, S, 8'd40)));
      issue("s6", 2'd1, RD, 3'b010, 8'd0, 5'b01_010, 1'b1, 3'b010);
      check("s6.mem2",  32'(dut.m.mem[2]), 32'd30);
      check("s6.c0[2]", 32'(dut.c0.cache_data[2]), 32'(ln(3'b010, S, 8'd30)));
      check("s6.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b010, S, 8'd30)));

      // Write miss on a tag that matches but is INVALID, then a silent upgrade
      issue("s7", 2'd2, WR, 3'b010, 8'd60, 5'b10_010, 1'b0, 3'b100);
      check("s7.c0[2]", 32'(dut.c0.cache_data[2]), 32'(ln(3'b010, I, 8'd30)));
      check("s7.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b010, I, 8'd30)));
      check("s7.c2[2]", 32'(dut.c2.cache_data[2]), 32'(ln(3'b010, M, 8'd60)));
      issue("s8", 2'd1, RD, 3'b110, 8'd0, 5'b01_110, 1'b0, 3'b010);
      check("s8.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b110, E, 8'd50)));
      issue("s9", 2'd1, WR, 3'b110, 8'd40, 5'b00_000, 1'b0, 3'b000);
      check("s9.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b110, M, 8'd40)));

      // Victim write-back
      issue("s10", 2'd1, RD, 3'b001, 8'd0, 5'b01_001, 1'b1, 3'b010);
      check("s10.mem5",  32'(dut.m.mem[5]), 32'd68);
      check("s10.c0[1]", 32'(dut.c0.cache_data[1]), 32'(ln(3'b001, S, 8'd8)));
      check("s10.c2[1]", 32'(dut.c2.cache_data[1]), 32'(ln(3'b001, S, 8'd8)));
      check("s10.c1[1]", 32'(dut.c1.cache_data[1]), 32'(ln(3'b001, S, 8'd8)));

      // Victim write-back and snooper supply in the same cycle
      issue("s11", 2'd2, RD, 3'b110, 8'd0, 5'b01_110, 1'b1, 3'b100);
      check("s11.mem2",  32'(dut.m.mem[2]), 32'd60);
      check("s11.mem6",  32'(dut.m.mem[6]), 32'd40);
      check("s11.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b110, S, 8'd40)));
      check("s11.c2[2]", 32'(dut.c2.cache_data[2]), 32'(ln(3'b110, S, 8'd40)));

      // A no-op and a read hit change nothing and drive no bus message.
      issue("nop", 2'd3, WR, 3'b110, 8'd99, 5'b00_000, 1'b0, 3'b000);
      check("nop.c2[2]", 32'(dut.c2.cache_data[2]), 32'(ln(3'b110, S, 8'd40)));
      issue("rhit", 2'd2, RD, 3'b110, 8'd0, 5'b00_000, 1'b0, 3'b000);
      check("rhit.c2[2]", 32'(dut.c2.cache_data[2]), 32'(ln(3'b110, S, 8'd40)));
      check("rhit.c1[2]", 32'(dut.c1.cache_data[2]), 32'(ln(3'b110, S, 8'd40)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
